// File: rtl/spawn_pkg.sv
// -----------------------------------------------------------------------------
// spawn_pkg
// Shared types and widths for the spawn scheduler:
//   state_e      - scheduler FSM states (IDLE, WAIT, DRAW, OFFER)
//   RND_W        - width of the LFSR random value and of a lane index
//   GAP_W        - width of the frame-tick gap counter
//   CNT_W        - width of the accepted-spawn counter
//   REJ_W        - width of the consecutive-reject counter
//   gap_from_rnd - gap load value: min_gap plus the low three random bits
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package spawn_pkg;

  localparam int RND_W = 5;
  localparam int GAP_W = 5;
  localparam int CNT_W = 8;
  localparam int REJ_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAW  = 2'd2,
    OFFER = 2'd3
  } state_e;

  // MIN_GAP is at most 24 and rnd[2:0] at most 7, so the sum fits in GAP_W.
  function automatic logic [GAP_W-1:0] gap_from_rnd(
    input logic [RND_W-1:0] r,
    input int unsigned      min_gap
  );
    return GAP_W'(min_gap) + GAP_W'(r[2:0]);
  endfunction

endpackage

// File: rtl/gap_timer.sv
// -----------------------------------------------------------------------------
// gap_timer
// Counts down the number of frame ticks to wait before a lane draw.
// Ports:
//   clock      - sole clock
//   reset      - synchronous, active-high reset
//   load_i     - load load_val_i into the counter this cycle
//   load_val_i - gap value (in ticks) to load
//   tick_i     - frame tick, already qualified by the caller (only counts in WAIT)
//   done_o     - combinational: the tick arriving now is the last one of the gap
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module gap_timer
  import spawn_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [GAP_W-1:0] load_val_i,
  input  logic             tick_i,
  output logic             done_o
);

  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_d;

  assign done_o = tick_i && (gap_q == GAP_W'(1));

  always_comb begin
    // NOTE: next-state defaults to the current value before any branch, so no
    // path leaves gap_d unassigned and no latch is inferred.
    gap_d = gap_q;
    if (load_i) begin
      gap_d = load_val_i;
    end else if (tick_i && (gap_q != '0)) begin
      gap_d = gap_q - GAP_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clock) begin
    if (reset) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/spawn_scheduler.sv
// -----------------------------------------------------------------------------
// spawn_scheduler
// Turns a free-running 5-bit LFSR value into paced, range-limited spawn
// requests. After a random number of frame ticks it draws a lane index in
// [0, NUM_LANES) by rejection sampling (never repeating the previous lane,
// with a deterministic fallback after MAX_REJECT rejects) and offers it on a
// valid/ack handshake.
// Parameters:
//   NUM_LANES  - number of legal lanes (2..32)
//   MIN_GAP    - minimum ticks between spawns (1..24)
//   MAX_REJECT - draw attempts before fallback (1..15)
// Ports:
//   clock       - sole clock
//   reset       - synchronous, active-high reset
//   enable      - scheduler runs while high
//   tick        - one-cycle frame pulse
//   rnd         - random value from the LFSR, sampled synchronously
//   spawn_ack   - consumer accepts the offered lane
//   spawn_valid - lane offer pending (registered)
//   spawn_lane  - offered lane, stable while spawn_valid (registered)
//   spawn_count - accepted spawns, wraps 255 -> 0 (registered)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spawn_scheduler
  import spawn_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 20,
  parameter int unsigned MIN_GAP    = 4,
  parameter int unsigned MAX_REJECT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             tick,
  input  logic [RND_W-1:0] rnd,
  input  logic             spawn_ack,
  output logic             spawn_valid,
  output logic [RND_W-1:0] spawn_lane,
  output logic [CNT_W-1:0] spawn_count
);

  // One extra bit so NUM_LANES = 32 is still representable.
  localparam logic [RND_W:0]   LANES_LIMIT = (RND_W+1)'(NUM_LANES);
  localparam logic [RND_W-1:0] LAST_LANE   = RND_W'(NUM_LANES - 1);
  localparam logic [REJ_W-1:0] REJ_FINAL   = REJ_W'(MAX_REJECT - 1);

  state_e           state_q,     state_d;
  logic [REJ_W-1:0] rej_q,       rej_d;
  logic             have_last_q, have_last_d;
  logic [RND_W-1:0] last_q,      last_d;
  logic             valid_q,     valid_d;
  logic [RND_W-1:0] lane_q,      lane_d;
  logic [CNT_W-1:0] count_q,     count_d;

  logic             gap_load;
  logic             timer_tick;
  logic             gap_done;
  logic             draw_ok;
  logic [RND_W-1:0] fallback_lane;

  // Ticks only count while waiting with the scheduler enabled; ticks seen in
  // any other state are simply dropped.
  gap_timer u_gap_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (gap_load),
    .load_val_i (gap_from_rnd(rnd, MIN_GAP)),
    .tick_i     (timer_tick),
    .done_o     (gap_done)
  );

  // A draw is usable when it is a legal lane and differs from the last
  // accepted lane (once there is one).
  assign draw_ok = ({1'b0, rnd} < LANES_LIMIT) && !(have_last_q && (rnd == last_q));

  // Fallback steps to the lane after the last one, or lane 0 if none yet.
  assign fallback_lane = !have_last_q        ? '0 :
                         (last_q == LAST_LANE) ? '0 :
                         last_q + RND_W'(1);

  always_comb begin
    state_d     = state_q;
    rej_d       = rej_q;
    have_last_d = have_last_q;
    last_d      = last_q;
    valid_d     = valid_q;
    lane_d      = lane_q;
    count_d     = count_q;
    gap_load    = 1'b0;
    timer_tick  = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          gap_load = 1'b1;
          state_d  = WAIT;
        end
      end

      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          timer_tick = tick;
          if (gap_done) begin
            state_d = DRAW;
            rej_d   = '0;
          end
        end
      end

      DRAW: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (draw_ok) begin
          lane_d  = rnd;
          valid_d = 1'b1;
          state_d = OFFER;
        end else begin
          rej_d = rej_q + REJ_W'(1);
          if (rej_q == REJ_FINAL) begin
            lane_d  = fallback_lane;
            valid_d = 1'b1;
            state_d = OFFER;
          end
        end
      end

      OFFER: begin
        // The offer stays up regardless of enable until it is acknowledged.
        if (spawn_ack) begin
          last_d      = lane_q;
          have_last_d = 1'b1;
          count_d     = count_q + CNT_W'(1);
          valid_d     = 1'b0;
          if (enable) begin
            gap_load = 1'b1;
            state_d  = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rej_q       <= '0;
      have_last_q <= 1'b0;
      last_q      <= '0;
      valid_q     <= 1'b0;
      lane_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rej_q       <= rej_d;
      have_last_q <= have_last_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      lane_q      <= lane_d;
      count_q     <= count_d;
    end
  end

  assign spawn_valid = valid_q;
  assign spawn_lane  = lane_q;
  assign spawn_count = count_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spawn_scheduler
// Self-checking bench for spawn_scheduler. The driver knows exactly which
// cycles are WAIT/DRAW because it generates every tick; a transaction-level
// model turns (seed, draw list, last lane) into the expected gap, number of
// draw cycles and lane. Expected offers go into a queue that a negedge
// monitor pops on every accepted handshake.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spawn_scheduler;

  localparam int NUM_LANES  = 20;
  localparam int MIN_GAP    = 4;
  localparam int MAX_REJECT = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       tick;
  logic [4:0] rnd;
  logic       spawn_ack;
  logic       spawn_valid;
  logic [4:0] spawn_lane;
  logic [7:0] spawn_count;

  always #5 clock = ~clock;

  spawn_scheduler #(
    .NUM_LANES  (NUM_LANES),
    .MIN_GAP    (MIN_GAP),
    .MAX_REJECT (MAX_REJECT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .tick        (tick),
    .rnd         (rnd),
    .spawn_ack   (spawn_ack),
    .spawn_valid (spawn_valid),
    .spawn_lane  (spawn_lane),
    .spawn_count (spawn_count)
  );

  typedef struct {
    int lane;
    int count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int   m_last      = 0;
  bit   m_have_last = 1'b0;
  int   m_count     = 0;
  bit   fast_ticks  = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs read here reflect that edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_tick();
    tick = fast_ticks ? 1'b1 : ($urandom_range(0, 2) == 0);
  endtask

  // Lane chosen by rejection sampling over the draw list; 'used' is the
  // number of DRAW cycles consumed.
  function automatic int pick_lane(input int draws[$], output int used);
    int rej;
    rej  = 0;
    used = draws.size();
    for (int i = 0; i < draws.size(); i++) begin
      if (draws[i] < NUM_LANES && !(m_have_last && draws[i] == m_last)) begin
        used = i + 1;
        return draws[i];
      end
      rej++;
      if (rej == MAX_REJECT) begin
        used = i + 1;
        return m_have_last ? (m_last + 1) % NUM_LANES : 0;
      end
    end
    return -1;
  endfunction

  // Runs load (unless already loaded by a back-to-back ack), WAIT and DRAW;
  // returns with the DUT expected to be presenting the offer.
  task automatic do_spawn(input logic [4:0] seed, input int draws[$], input bit from_offer,
                          output int lane);
    int   gap;
    int   ticks;
    int   used;
    exp_t e;
    if (!from_offer) begin
      enable    = 1'b1;
      rnd       = seed;
      spawn_ack = 1'b0;
      rand_tick();
      cyc();
    end
    gap   = MIN_GAP + int'(seed[2:0]);
    ticks = 0;
    while (ticks < gap) begin
      enable = 1'b1;
      rnd    = 5'($urandom);
      rand_tick();
      cyc();
      if (tick) ticks++;
      check("valid_low_wait", spawn_valid, 0);
    end
    lane    = pick_lane(draws, used);
    e.lane  = lane;
    e.count = m_count;
    exp_q.push_back(e);
    for (int i = 0; i < used; i++) begin
      rnd = 5'(draws[i]);
      rand_tick();
      cyc();
      check((i == used - 1) ? "valid_rise" : "valid_low_draw", spawn_valid, (i == used - 1));
    end
    tick = 1'b0;
  endtask

  // Holds the offer for 'delay' cycles (optionally with enable dropped), then
  // acknowledges with enable=next_en and rnd=next_seed.
  task automatic finish_offer(input int delay, input bit drop, input bit next_en,
                              input logic [4:0] next_seed, input int lane);
    for (int i = 0; i < delay; i++) begin
      spawn_ack = 1'b0;
      enable    = !drop;
      rnd       = 5'($urandom);
      rand_tick();
      cyc();
      check("valid_held", spawn_valid, 1);
      check("lane_held", spawn_lane, lane);
    end
    spawn_ack = 1'b1;
    enable    = next_en;
    rnd       = next_seed;
    rand_tick();
    cyc();
    m_last      = lane;
    m_have_last = 1'b1;
    m_count     = (m_count + 1) % 256;
    spawn_ack   = 1'b0;
    check("valid_fall", spawn_valid, 0);
    check("count_after_ack", spawn_count, m_count);
  endtask

  task automatic idle_cycles(input int n);
    enable    = 1'b0;
    spawn_ack = 1'b0;
    for (int i = 0; i < n; i++) begin
      rnd = 5'($urandom);
      rand_tick();
      cyc();
      check("valid_low_idle", spawn_valid, 0);
    end
  endtask

  // Monitor: every accepted handshake must match the oldest expected offer.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && spawn_valid && spawn_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_accept: lane %0d accepted, no offer expected", spawn_lane);
      end else begin
        e = exp_q.pop_front();
        check("lane", spawn_lane, e.lane);
        check("count_at_ack", spawn_count, e.count);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int         lane;
    int         d[$];
    int         v;
    exp_t       dropped;
    logic [4:0] seed;
    logic [4:0] nseed;
    bit         b2b;
    bit         nb2b;

    reset     = 1'b1;
    enable    = 1'b0;
    tick      = 1'b0;
    rnd       = '0;
    spawn_ack = 1'b0;
    cyc();
    cyc();
    check("reset_valid", spawn_valid, 0);
    check("reset_lane",  spawn_lane,  0);
    check("reset_count", spawn_count, 0);
    // Reset dominates an active enable/tick.
    enable = 1'b1;
    tick   = 1'b1;
    cyc();
    check("reset_dominates_valid", spawn_valid, 0);
    reset  = 1'b0;
    enable = 1'b0;
    tick   = 1'b0;
    cyc();

    // First spawn: seed 3 -> gap 7, draw 12 accepted.
    d = '{12};
    do_spawn(5'd3, d, 1'b0, lane);
    finish_offer(1, 1'b0, 1'b1, 5'd6, lane);
    // Rejection: 25 and 31 out of range, then 5 -> three DRAW cycles.
    d = '{25, 31, 5};
    do_spawn(5'd6, d, 1'b1, lane);
    finish_offer(0, 1'b0, 1'b1, 5'd1, lane);
    // No repeat: last is 5, draw 5 rejected, 9 accepted.
    d = '{5, 9};
    do_spawn(5'd1, d, 1'b1, lane);
    finish_offer(2, 1'b0, 1'b1, 5'd0, lane);
    // Set up last lane 19 for the fallback case.
    d = '{19};
    do_spawn(5'd0, d, 1'b1, lane);
    finish_offer(0, 1'b0, 1'b1, 5'd7, lane);
    // Fallback: eight rejects of 30 -> (19+1) mod 20 = 0.
    d.delete();
    for (int i = 0; i < MAX_REJECT; i++) d.push_back(30);
    do_spawn(5'd7, d, 1'b1, lane);
    finish_offer(0, 1'b0, 1'b0, 5'd0, lane);
    idle_cycles(2);

    // Enable drop in WAIT: return to IDLE; the next spawn reloads a fresh gap.
    enable = 1'b1;
    rnd    = 5'd2;
    tick   = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      rnd  = 5'($urandom);
      cyc();
      check("valid_low_wait_pre_drop", spawn_valid, 0);
    end
    enable = 1'b0;
    tick   = 1'b1;
    cyc();
    check("valid_low_after_drop", spawn_valid, 0);
    idle_cycles(3);
    d = '{14};
    do_spawn(5'd5, d, 1'b0, lane);
    // Enable drop in OFFER: offer held until ack, then IDLE.
    finish_offer(3, 1'b1, 1'b0, 5'd0, lane);
    idle_cycles(2);

    // Synchronous reset mid-OFFER with ack asserted.
    d = '{11};
    do_spawn(5'd4, d, 1'b0, lane);
    reset     = 1'b1;
    spawn_ack = 1'b1;
    enable    = 1'b1;
    cyc();
    check("rst_offer_valid", spawn_valid, 0);
    check("rst_offer_count", spawn_count, 0);
    check("rst_offer_lane",  spawn_lane,  0);
    reset     = 1'b0;
    spawn_ack = 1'b0;
    enable    = 1'b0;
    dropped   = exp_q.pop_front();
    m_count     = 0;
    m_have_last = 1'b0;
    cyc();
    // Old lane 11 is legal again because have_last was cleared.
    d = '{11};
    do_spawn(5'd0, d, 1'b0, lane);
    finish_offer(1, 1'b0, 1'b0, 5'd0, lane);
    idle_cycles(2);

    // Randomized spawns: random draws (biased towards repeats), delays,
    // enable drops during offers, back-to-back or idle between spawns.
    seed = 5'($urandom);
    b2b  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      d.delete();
      for (int j = 0; j < MAX_REJECT; j++) begin
        v = $urandom_range(0, 31);
        if ($urandom_range(0, 3) == 0) v = m_last;
        d.push_back(v);
      end
      do_spawn(seed, d, b2b, lane);
      nseed = 5'($urandom);
      nb2b  = ($urandom_range(0, 1) == 1);
      finish_offer($urandom_range(0, 3), ($urandom_range(0, 3) == 0), nb2b, nseed, lane);
      if (!nb2b) idle_cycles($urandom_range(0, 3));
      seed = nseed;
      b2b  = nb2b;
    end

    // Fast back-to-back run with a tick every cycle to wrap spawn_count.
    fast_ticks = 1'b1;
    seed = 5'($urandom);
    b2b  = 1'b0;
    for (int k = 0; k < 260; k++) begin
      do begin
        v = $urandom_range(0, NUM_LANES - 1);
      end while (m_have_last && v == m_last);
      d.delete();
      d.push_back(v);
      do_spawn(seed, d, b2b, lane);
      nseed = 5'($urandom);
      nb2b  = (k != 259);
      finish_offer(0, 1'b0, nb2b, nseed, lane);
      seed = nseed;
      b2b  = nb2b;
    end
    fast_ticks = 1'b0;
    idle_cycles(3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spawn_scheduler.md
# spawn_scheduler

- Downstream consumer of the 5-bit LFSR random source.
- Turns the free-running random value into paced, range-limited spawn requests for the game logic.
- Waits a random number of frame ticks, draws a lane index in `[0, NUM_LANES)` by rejection sampling, and never repeats the previous lane.
- Offers the lane on a valid/ack handshake to the object-spawn logic.

## Interface
Parameters:
- `NUM_LANES`, 20: number of legal lanes, 2..32.
- `MIN_GAP`, 4: minimum ticks between spawns, 1..24.
- `MAX_REJECT`, 8: draw attempts before fallback, 1..15.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset; one clock; no async path.
- `enable`  in  1  level; scheduler runs while high.
- `tick`  in  1  one-cycle frame pulse.
- `rnd`  in  5  random value from LFSR; may change any cycle; sampled synchronously only.
- `spawn_ack`  in  1  consumer accepts the offered lane.
- `spawn_valid`  out  1  lane offer pending.
- `spawn_lane`  out  5  offered lane; stable while `spawn_valid`.
- `spawn_count`  out  8  accepted spawns; wraps 255→0.

## Operation
- States: IDLE, WAIT, DRAW, OFFER.
- Reset values:
  - state IDLE
  - `spawn_valid` 0
  - `spawn_lane` 0
  - `spawn_count` 0
  - gap 0
  - reject count 0
  - `have_last` 0
- **IDLE:**
  - If `enable`, load gap = `MIN_GAP` + `rnd[2:0]` (5-bit) and go to WAIT.
- **WAIT:**
  - `enable`=0 → IDLE.
  - Else on `tick`: if gap==1 → DRAW, else gap−1.
  - Non-tick cycles hold gap.
- **DRAW:** one attempt per cycle; clears reject count on entry.
  - `enable`=0 → IDLE.
  - Accept `rnd` if `rnd < NUM_LANES` and not (`have_last` and `rnd` == last lane).
  - Accept → latch `spawn_lane`=`rnd`, go to OFFER.
  - Reject → reject count+1.
  - On the `MAX_REJECT`-th consecutive reject, take the fallback lane and go to OFFER:
    - `have_last`=1: (last+1) wrapped at `NUM_LANES`.
    - `have_last`=0: 0.
- **OFFER:**
  - `spawn_valid`=1; `spawn_lane` held.
  - On `spawn_ack`: record last lane, set `have_last`=1, `spawn_count`+1.
  - If `enable`: load gap = `MIN_GAP` + `rnd[2:0]`, go to WAIT.
  - Else go to IDLE.
  - An `enable` drop during OFFER never withdraws the offer; it waits for ack.
- `tick` in IDLE/DRAW/OFFER is ignored; ticks are not queued.
- `spawn_ack` without `spawn_valid` is ignored.

## Timing
- All outputs registered; a state change is visible the cycle after its condition.
- `spawn_valid` rises the cycle after an accepting DRAW cycle.
- `spawn_valid` falls the cycle after the ack cycle.
- Minimum enable→valid latency: 1 (IDLE) + gap ticks + 1 DRAW cycle.
- Back-to-back: ack and the new gap load occur in the same cycle.
- `reset` dominates every input in the same edge, including mid-OFFER; the offer is dropped and `have_last` is cleared.

## Structure
- Package `spawn_pkg` holds:
  - state enum (IDLE, WAIT, DRAW, OFFER)
  - `RND_W`=5, `GAP_W`=5, `CNT_W`=8
  - reject-counter width 4
- Sub-module `gap_timer`:
  - Loads on pulse, decrements on `tick`, flags `done` when gap==1 and `tick`.
  - Instanced once.
- FSM, lane picker and counters live in `spawn_scheduler`. Target 150–250 lines.

## Test plan
- **Reset and first spawn:** `enable`=1, `rnd`=3 in IDLE.
  - Gap=7; WAIT exits after 7th tick.
  - DRAW with `rnd`=12 → `spawn_valid`=1, `spawn_lane`=12 next cycle.
  - Ack → `spawn_count`=1.
- **Rejection:** DRAW sees `rnd`=25, 31, then 5 (`NUM_LANES`=20).
  - Exactly 3 DRAW cycles, then `spawn_lane`=5.
- **No repeat:** last lane 5; DRAW sees `rnd`=5 then 9 → lane 9.
- **Fallback:** last lane 19; `rnd` held at 30 for 8 cycles → lane 0 on the 8th.
- **Enable drop:**
  - Drop in WAIT → IDLE next cycle, no valid.
  - Drop in OFFER → valid held until ack, then IDLE with count incremented.
- **Sync reset mid-OFFER with ack asserted:**
  - `spawn_valid`=0 and `spawn_count`=0 next cycle.
  - Next draw may repeat the old lane.
